// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for a systolic-array TPU: per tile it loads one weight set,
// streams input vectors from the UB and writes results back after a fixed latency.
module tpu_tile_sequencer #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned TILE_BW     = 4,
    parameter int unsigned RES_LAT     = 65
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_num_rows,
    input  logic [TILE_BW-1:0]     cfg_num_tiles,
    input  logic [ADDRESSSIZE-1:0] cfg_ub_base,
    input  logic [ADDRESSSIZE-1:0] cfg_res_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_read_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done,
    output logic [TILE_BW-1:0]     tile_idx
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAITW = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FEED  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [ADDRESSSIZE-1:0] num_rows_r;
    logic [ADDRESSSIZE-1:0] row_cnt_r;
    logic [ADDRESSSIZE-1:0] ub_addr_r;
    logic [ADDRESSSIZE-1:0] res_addr_r;
    logic [TILE_BW-1:0]     num_tiles_r;
    logic [TILE_BW-1:0]     tile_idx_r;
    logic [RES_LAT-1:0]     vline_r;
    logic                   fifo_rd_r;
    logic                   ub_rd_r;
    logic                   busy_r;
    logic                   done_r;

    logic accept_s;
    logic cancel_s;
    logic last_row_s;
    logic last_tile_s;
    logic line_empty_s;
    logic tile_adv_s;

    assign accept_s     = (state_r == ST_IDLE) && start && !abort;
    assign cancel_s     = (state_r != ST_IDLE) && abort;
    assign last_row_s   = (row_cnt_r == (num_rows_r - ADDRESSSIZE'(1)));
    assign last_tile_s  = ((tile_idx_r + TILE_BW'(1)) == num_tiles_r);
    assign line_empty_s = (vline_r == {RES_LAT{1'b0}});
    assign tile_adv_s   = (state_r == ST_DRAIN) && (state_s == ST_WAITW);

    // Next-state decode; abort overrides every non-idle state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((cfg_num_rows == {ADDRESSSIZE{1'b0}}) || (cfg_num_tiles == {TILE_BW{1'b0}})) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAITW;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAITW: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_WAITW;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_FEED: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (last_row_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (!line_empty_s) begin
                    state_s = ST_DRAIN;
                end else if (last_tile_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAITW;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and strobes registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            fifo_rd_r <= 1'b0;
            ub_rd_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            fifo_rd_r <= (state_s == ST_LOAD);
            ub_rd_r   <= (state_s == ST_FEED);
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Result-valid line: the oldest stage drives the result write strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vline_r <= {RES_LAT{1'b0}};
        end else if (cancel_s) begin
            vline_r <= {RES_LAT{1'b0}};
        end else begin
            vline_r <= {vline_r[RES_LAT-2:0], ub_rd_r};
        end
    end

    // Row counter within the current FEED burst.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt_r <= {ADDRESSSIZE{1'b0}};
        end else if (state_r == ST_FEED) begin
            row_cnt_r <= row_cnt_r + ADDRESSSIZE'(1);
        end else begin
            row_cnt_r <= {ADDRESSSIZE{1'b0}};
        end
    end

    // Job configuration, tile index and address pointers (contiguous across tiles).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_rows_r  <= {ADDRESSSIZE{1'b0}};
            num_tiles_r <= {TILE_BW{1'b0}};
            ub_addr_r   <= {ADDRESSSIZE{1'b0}};
            res_addr_r  <= {ADDRESSSIZE{1'b0}};
            tile_idx_r  <= {TILE_BW{1'b0}};
        end else if (accept_s) begin
            num_rows_r  <= cfg_num_rows;
            num_tiles_r <= cfg_num_tiles;
            ub_addr_r   <= cfg_ub_base;
            res_addr_r  <= cfg_res_base;
            tile_idx_r  <= {TILE_BW{1'b0}};
        end else begin
            if (state_r == ST_FEED) begin
                ub_addr_r <= ub_addr_r + ADDRESSSIZE'(1);
            end
            if (vline_r[RES_LAT-1]) begin
                res_addr_r <= res_addr_r + ADDRESSSIZE'(1);
            end
            if (tile_adv_s) begin
                tile_idx_r <= tile_idx_r + TILE_BW'(1);
            end
        end
    end

    assign fifo_read_enable = fifo_rd_r;
    assign we_rl            = fifo_rd_r;
    assign ub_read_en       = ub_rd_r;
    assign ub_address       = ub_addr_r;
    assign res_write_enable = vline_r[RES_LAT-1];
    assign res_address      = res_addr_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign tile_idx         = tile_idx_r;

endmodule

// File: doc/tpu_tile_sequencer.md
TPU_TILE_SEQUENCER -- requirements
Module: tpu_tile_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDRESSSIZE  10  UB and result-SRAM address width
  TILE_BW      4   tile-count width
  RES_LAT      65  cycles from a UB read to its result being ready for write-back
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk               in   1            single clock, rising edge
  rstn              in   1            asynchronous active-low reset
  start             in   1            job request, sampled in IDLE only
  abort             in   1            synchronous job cancel
  cfg_num_rows      in   ADDRESSSIZE  input vectors per tile
  cfg_num_tiles     in   TILE_BW      tiles per job
  cfg_ub_base       in   ADDRESSSIZE  first UB read address
  cfg_res_base      in   ADDRESSSIZE  first result write address
  fifo_empty        in   1            weight FIFO empty flag
  fifo_read_enable  out  1            pop one weight set
  we_rl             out  1            systolic-array weight reload
  ub_read_en        out  1            UB read strobe, one vector per cycle
  ub_address        out  ADDRESSSIZE  UB read address
  res_write_enable  out  1            result SRAM write strobe
  res_address       out  ADDRESSSIZE  result SRAM write address
  busy              out  1            high whenever state is not IDLE
  done              out  1            one-cycle job-complete pulse
  tile_idx          out  TILE_BW      index of the current tile

Function
REQ-003 The FSM SHALL have the states IDLE, WAITW, LOAD, FEED, DRAIN and DONE; the state is registered and every output is decoded from registered state or registers.
REQ-004 In IDLE, when start=1 and abort=0, the block SHALL latch all cfg_* inputs and clear tile_idx; it then goes to DONE if cfg_num_rows=0 or cfg_num_tiles=0, else to WAITW.
REQ-005 WAITW SHALL hold while fifo_empty=1; when fifo_empty=0 it goes to LOAD.
REQ-006 LOAD SHALL last exactly one cycle, with fifo_read_enable=we_rl=1, then go to FEED.
REQ-007 FEED SHALL last exactly num_rows cycles.
  - ub_read_en=1 throughout.
  - ub_address starts at the latched ub_base on the first tile.
  - The address increments by 1 per cycle, modulo 2^ADDRESSSIZE.
  - The address continues contiguously across tiles.
REQ-008 ub_read_en SHALL feed a RES_LAT-deep valid shift line; res_write_enable equals ub_read_en delayed exactly RES_LAT cycles.
REQ-009 res_address SHALL start at the latched res_base and increment by 1 modulo 2^ADDRESSSIZE after each write, contiguously across tiles.
REQ-010 FEED SHALL go to DRAIN after its last cycle.
REQ-011 DRAIN SHALL exit in the first cycle where all valid-line stages, including the one driving res_write_enable, are 0.
  - If tile_idx+1 = num_tiles: next state DONE.
  - Otherwise: tile_idx increments and next state WAITW.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle; the next state is IDLE.
REQ-013 start SHALL be ignored in every state other than IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, clear the valid line, and produce no done pulse.
REQ-015 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE.
REQ-016 fifo_read_enable SHALL pulse exactly num_tiles times per completed job and never while fifo_empty=1 was sampled in the preceding WAITW cycle.

Reset
REQ-017 rstn=0 SHALL immediately, asynchronously, force IDLE and clear the valid line, tile_idx, the pointers, latched config and all outputs to 0.
REQ-018 A reset in mid-job SHALL abandon the job with no done pulse; the block SHALL accept start on the first edge after rstn rises.

Verification (RES_LAT=4, ADDRESSSIZE=10; cycle 0 = the start cycle)
REQ-019 Single tile: rows=3, tiles=1, ub_base=10, res_base=100, fifo_empty=0.
  - WAITW at cycle 1; LOAD at cycle 2.
  - ub_address 10/11/12 in cycles 3-5.
  - res_write_enable in cycles 7-9 with res_address 100/101/102.
  - done in cycle 11; busy=0 from cycle 12.
REQ-020 Wrap: ub_base=1023, res_base=1023, rows=2 -> ub_address 1023 then 0; res_address 1023 then 0.
REQ-021 Two tiles, rows=2, with fifo_empty=1 for 5 cycles before tile 1:
  - WAITW holds for those 5 cycles.
  - fifo_read_enable pulses exactly twice.
  - ub_address runs 0-3 contiguous; tile_idx=1 during the second FEED.
REQ-022 Abort in the 2nd FEED cycle -> IDLE next cycle; busy=0; res_write_enable never asserts; done never asserts.
REQ-023 Zero configuration: rows=0 or tiles=0 -> done in cycle 1; no fifo_read_enable, ub_read_en or res_write_enable ever asserts.
REQ-024 Reset in DRAIN and start while busy:
  - rstn pulsed low in DRAIN -> all outputs 0 immediately.
  - A start issued while busy has no effect on the addresses or the tile count.
